// File: rtl/spi_sram_line_buffer_pkg.sv
// Shared types and constants for the SPI SRAM line buffer.
// Latency: none (declarations only).
// Backpressure: n/a.
package spi_sram_pkg;

  // Line buffer controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_e;

  // spi_sram_master takes a 24-bit byte address.
  localparam int MEM_ADDR_W = 24;

  // Width of the byte-offset field inside a line; never narrower than one bit.
  function automatic int off_width(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/spi_sram_line_buffer_if.sv
// Request/response bus between the line buffer and spi_sram_master.
// Latency: set by the slave; a request completes with a one-cycle mem_ready pulse.
// Backpressure: mem_en and the request fields are held until mem_ready.
// Ports (master = line buffer, slave = SPI SRAM side):
//   mem_addr, mem_en, mem_wr, mem_wdata : master -> slave
//   mem_rdata, mem_ready                : slave  -> master
interface spi_sram_line_buffer_if;
  logic [spi_sram_pkg::MEM_ADDR_W-1:0] mem_addr;
  logic                                mem_en;
  logic                                mem_wr;
  logic [7:0]                          mem_wdata;
  logic [7:0]                          mem_rdata;
  logic                                mem_ready;

  modport master (
    output mem_addr, mem_en, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_en, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/spi_sram_line_buffer.sv
// One-line read buffer between the 6502 core bus and spi_sram_master; writes go through.
// Latency: read hit returns data one cycle after cpu_rdy; a miss fills the whole line first.
// Backpressure: cpu_rdy low stalls the core while a fill or write is on the serial link.
// Ports: clk, rst (async, active-high); cpu_addr/cpu_we/cpu_wdata in, cpu_rdata (registered)
//   and cpu_rdy (combinational) out; mem = spi_sram_line_buffer_if.master.
// Option SPI_SRAM_LINE_STATS_EN adds saturating hit_count/miss_count outputs.
module spi_sram_line_buffer
  import spi_sram_pkg::*;
#(
  parameter int LINE_BYTES = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          cpu_we,
  input  logic [7:0]                    cpu_wdata,
  output logic [7:0]                    cpu_rdata,
  output logic                          cpu_rdy,
`ifdef SPI_SRAM_LINE_STATS_EN
  output logic [15:0]                   hit_count,
  output logic [15:0]                   miss_count,
`endif
  spi_sram_line_buffer_if.master        mem
);

  localparam int OFF_W = off_width(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_BYTES - 1);

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [7:0]            line_q [LINE_BYTES];
  logic [7:0]            line_d [LINE_BYTES];
  logic [OFF_W-1:0]      idx_q, idx_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;

  logic [OFF_W-1:0]      cpu_off;
  logic [TAG_W-1:0]      cpu_tag;
  logic                  hit;
  logic                  rd_accept;

  assign cpu_off = cpu_addr[OFF_W-1:0];
  assign cpu_tag = cpu_addr[ADDR_W-1:OFF_W];
  assign hit     = valid_q && (tag_q == cpu_tag);

  // rst gates cpu_rdy directly so the core never sees ready during reset.
  assign cpu_rdy   = !rst && ((state_q == IDLE && !cpu_we && hit) || state_q == WDONE);
  // Reads complete only from IDLE; the WDONE ready belongs to a write.
  assign rd_accept = (state_q == IDLE) && cpu_rdy && !cpu_we;

  assign cpu_rdata     = rdata_q;
  assign mem.mem_en    = mem_en_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    line_d      = line_q;
    idx_d       = idx_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (rd_accept) begin
      rdata_d = line_q[cpu_off];
    end

    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          state_d     = WRITE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = MEM_ADDR_W'(cpu_addr);
          mem_wdata_d = cpu_wdata;
          // Write-through: keep the buffered copy coherent on a hit, never allocate.
          if (hit) begin
            line_d[cpu_off] = cpu_wdata;
          end
        end else if (!hit) begin
          // The line is overwritten byte by byte, so it stops being valid now.
          state_d    = FILL;
          valid_d    = 1'b0;
          idx_d      = '0;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = MEM_ADDR_W'({cpu_tag, {OFF_W{1'b0}}});
        end
      end
      FILL: begin
        if (mem.mem_ready) begin
          line_d[idx_q] = mem.mem_rdata;
          if (idx_q == LAST_IDX) begin
            valid_d  = 1'b1;
            tag_d    = mem_addr_q[ADDR_W-1:OFF_W];
            mem_en_d = 1'b0;
            state_d  = IDLE;
          end else begin
            // Offset bits never carry into the tag here, so +1 stays inside the line.
            idx_d      = idx_q + 1'b1;
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (mem.mem_ready) begin
          mem_en_d = 1'b0;
          state_d  = WDONE;
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < LINE_BYTES; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      line_q      <= line_d;
    end
  end

`ifdef SPI_SRAM_LINE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rd_accept && hit_cnt_q != 16'hFFFF) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (state_q == IDLE && state_d == FILL && miss_cnt_q != 16'hFFFF) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_spi_sram_line_buffer.sv
// Self-checking bench for spi_sram_line_buffer: op table plus memory-request scoreboard.
// Latency: n/a.
// Backpressure: the SPI SRAM model answers each request after lat extra cycles.
module tb_spi_sram_line_buffer;
  import spi_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
`ifdef SPI_SRAM_LINE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  always #5 clk = ~clk;

  spi_sram_line_buffer_if mem_if();

  spi_sram_line_buffer #(.LINE_BYTES(4), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
`ifdef SPI_SRAM_LINE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .mem       (mem_if)
  );

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
  } req_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        exp_fill;
    logic        exp_rdy_now;
    string       name;
  } op_t;

  req_t       exp_q[$];
  op_t        ops[12];
  logic [7:0] mem_model [65536];
  logic [7:0] ref_mem   [65536];
  int         errors = 0;
  int         checks = 0;
  int         lat = 0;
  int         done_cnt = 0;
  bit         stray_pending = 1'b0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic we, input logic [7:0] d,
                        input logic fill, input logic rdy, input string nm);
    ops[i].addr        = a;
    ops[i].we          = we;
    ops[i].wdata       = d;
    ops[i].exp_fill    = fill;
    ops[i].exp_rdy_now = rdy;
    ops[i].name        = nm;
  endtask

  // SPI SRAM model: acts 2 time units after each rising edge, completes after lat idle cycles.
  initial begin
    int   busy;
    req_t e;
    busy = 0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      mem_if.mem_ready = 1'b0;
      if (rst) begin
        busy = 0;
      end else if (!mem_if.mem_en) begin
        busy = 0;
        if (stray_pending) begin
          stray_pending    = 1'b0;
          mem_if.mem_ready = 1'b1;
          mem_if.mem_rdata = 8'hEE;
        end
      end else if (busy < lat) begin
        busy++;
      end else begin
        busy = 0;
        mem_if.mem_ready = 1'b1;
        done_cnt++;
        if (mem_if.mem_wr) mem_model[mem_if.mem_addr[15:0]] = mem_if.mem_wdata;
        else               mem_if.mem_rdata = mem_model[mem_if.mem_addr[15:0]];
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got request wr=%0b addr=0x%06h, expected none",
                   mem_if.mem_wr, mem_if.mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("mem_req_wr", 32'(mem_if.mem_wr), 32'(e.wr));
          check("mem_req_addr", 32'(mem_if.mem_addr), 32'(e.addr));
          if (e.wr) check("mem_req_wdata", 32'(mem_if.mem_wdata), 32'(e.data));
        end
      end
    end
  end

  // Drives one core access immediately, waits for cpu_rdy (bounded), checks read data.
  task automatic run_op(input op_t op);
    int          waited;
    logic [7:0]  rd_before;
    logic [7:0]  exp_data;
    logic [15:0] base;
    rd_before = cpu_rdata;
    cpu_addr  = op.addr;
    cpu_we    = op.we;
    cpu_wdata = op.wdata;
    base      = {op.addr[15:2], 2'b00};
    if (op.we) begin
      exp_q.push_back('{1'b1, {8'h00, op.addr}, op.wdata});
      ref_mem[op.addr] = op.wdata;
    end else if (op.exp_fill) begin
      for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, {8'h00, base + 16'(k)}, 8'h00});
    end
    exp_data = op.we ? rd_before : ref_mem[op.addr];
    waited = 0;
    @(negedge clk);
    check({op.name, " rdy_first"}, 32'(cpu_rdy), 32'(op.exp_rdy_now));
    while (!cpu_rdy && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!cpu_rdy) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: cpu_rdy=0 after 400 cycles, expected 1", op.name);
    end
    @(posedge clk);
    #1;
    check({op.name, " rdata"}, 32'(cpu_rdata), 32'(exp_data));
    check({op.name, " pending_reqs"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    op_t         op;
    int          start;
    int          waited;
    int          cyc;
    int          changes;
    int          viol;
    logic        prev_en;
    logic [23:0] prev_addr;

    rst       = 1'b1;
    cpu_addr  = 16'h0200;
    cpu_we    = 1'b0;
    cpu_wdata = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      mem_model[i] = pat(16'(i));
      ref_mem[i]   = pat(16'(i));
    end

    //     idx  addr      we    wdata  fill  rdy_now name
    set_op(0,  16'h0200, 1'b0, 8'h00, 1'b1, 1'b0, "cold_rd_0200");
    set_op(1,  16'h0201, 1'b0, 8'h00, 1'b0, 1'b1, "hit_rd_0201");
    set_op(2,  16'h0202, 1'b0, 8'h00, 1'b0, 1'b1, "hit_rd_0202");
    set_op(3,  16'h0203, 1'b0, 8'h00, 1'b0, 1'b1, "hit_rd_0203");
    set_op(4,  16'h0202, 1'b1, 8'hA5, 1'b0, 1'b0, "wr_hit_0202");
    set_op(5,  16'h0202, 1'b0, 8'h00, 1'b0, 1'b1, "rd_after_wr_0202");
    set_op(6,  16'h1000, 1'b1, 8'h3C, 1'b0, 1'b0, "wr_miss_1000");
    set_op(7,  16'h0201, 1'b0, 8'h00, 1'b0, 1'b1, "still_0200_line");
    set_op(8,  16'h1000, 1'b0, 8'h00, 1'b1, 1'b0, "fill_rd_1000");
    set_op(9,  16'h1003, 1'b0, 8'h00, 1'b0, 1'b1, "hit_rd_1003");
    set_op(10, 16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b0, "fill_rd_ffff");
    set_op(11, 16'hFFFC, 1'b0, 8'h00, 1'b0, 1'b1, "hit_rd_fffc");

    repeat (3) @(negedge clk);
    check("reset cpu_rdy", 32'(cpu_rdy), 32'd0);
    check("reset mem_en", 32'(mem_if.mem_en), 32'd0);
    check("reset mem_wr", 32'(mem_if.mem_wr), 32'd0);
    check("reset mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("reset mem_wdata", 32'(mem_if.mem_wdata), 32'd0);
    check("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(ops[i]);
`ifdef SPI_SRAM_LINE_STATS_EN
      if (i == 0) check("miss_count after cold fill", 32'(miss_count), 32'd1);
      if (i == 3) check("hit_count after sequential", 32'(hit_count), 32'd4);
`endif
    end

    // Reset two bytes into a slow fill of 0x0200.
    lat = 2;
    cpu_addr = 16'h0200;
    cpu_we   = 1'b0;
    exp_q.push_back('{1'b0, 24'h000200, 8'h00});
    exp_q.push_back('{1'b0, 24'h000201, 8'h00});
    start  = done_cnt;
    waited = 0;
    while (done_cnt - start < 2 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("midfill bytes before reset", 32'(done_cnt - start), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    check("midfill reset mem_en", 32'(mem_if.mem_en), 32'd0);
    check("midfill reset cpu_rdy", 32'(cpu_rdy), 32'd0);
    repeat (2) @(negedge clk);
    check("midfill reset held mem_en", 32'(mem_if.mem_en), 32'd0);
    check("midfill reset held cpu_rdy", 32'(cpu_rdy), 32'd0);
    check("midfill reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("midfill no stale reqs", 32'(exp_q.size()), 32'd0);
    lat = 0;
    rst = 1'b0;
    op = '{16'h0200, 1'b0, 8'h00, 1'b1, 1'b0, "refill_0200"};
    run_op(op);

    // Stray mem_ready while idle must not disturb the line.
    stray_pending = 1'b1;
    op = '{16'h0201, 1'b0, 8'h00, 1'b0, 1'b1, "stray_rdy_rd_0201"};
    run_op(op);
    op = '{16'h0202, 1'b0, 8'h00, 1'b0, 1'b1, "stray_rdy_rd_0202"};
    run_op(op);

    // Slow link: 40 extra cycles per byte; request fields must hold while mem_en is high.
    lat = 40;
    cpu_addr = 16'h3000;
    cpu_we   = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 24'h003000 + 24'(k), 8'h00});
    prev_en   = 1'b0;
    prev_addr = '0;
    changes   = 0;
    viol      = 0;
    cyc       = 0;
    @(negedge clk);
    while (!cpu_rdy && cyc < 400) begin
      if (mem_if.mem_en) begin
        if (mem_if.mem_wr) viol++;
        if (prev_en && mem_if.mem_addr != prev_addr) begin
          if (mem_if.mem_addr == prev_addr + 24'd1) changes++;
          else viol++;
        end
      end else if (prev_en) begin
        viol++;
      end
      prev_en   = mem_if.mem_en;
      prev_addr = mem_if.mem_addr;
      cyc++;
      @(negedge clk);
    end
    check("slow fill request violations", 32'(viol), 32'd0);
    check("slow fill address steps", 32'(changes), 32'd3);
    check("slow fill stall >= 160 cycles", 32'(cyc >= 160), 32'd1);
    check("slow fill rdy at end", 32'(cpu_rdy), 32'd1);
    @(posedge clk);
    #1;
    check("slow fill rdata", 32'(cpu_rdata), 32'(ref_mem[16'h3000]));
    check("slow fill pending_reqs", 32'(exp_q.size()), 32'd0);
    lat = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
